raster_to_block: RTL and testbench
==================================

// Module: raster_to_block
// PURPOSE
//  Front-end stage ahead of the 2D DCT. Accepts a frame in raster order, 8 pixels
//  (one 64-bit word) per beat, and buffers 8-row strips in a ping-pong line buffer.
//  Re-emits each strip as consecutive 8x8 blocks, one block row per beat: block 0
//  rows 0..7, then block 1 rows 0..7, and so on.
//  Supplies data_in plus a 15-bit word address to the DCT/quant/IDCT pipeline.
// PARAMETERS
//  IMG_W    512  frame width in pixels, multiple of 8
//  IMG_H    512  frame height in pixels, multiple of 8
//  WPR      IMG_W/8   derived; 64-bit words per row / blocks per strip
//  ADDR_W   15   width of out_addr
// PORTS
//  clk        in   1       single clock, all logic on posedge
//  reset      in   1       synchronous, active-high
//  in_data    in   64      8 pixels of one raster row; pixel 0 in [63:56]
//  in_valid   in   1       in_data valid
//  in_ready   out  1       stage can accept in_data this cycle
//  out_data   out  64      one row of an 8x8 block; pixel 0 in [63:56]
//  out_valid  out  1       out_data valid
//  out_ready  in   1       downstream accepts out_data
//  out_row    out  3       row index of out_data within its block
//  out_addr   out  ADDR_W  frame word index of out_data; 0 = first row of first block
//  out_sof    out  1       high with the frame's first output word (out_addr==0)
//  frame_done out  1       1-cycle pulse after the frame's last output word is accepted
// BEHAVIOUR
//  Reset (sync, active-high, takes effect mid-frame too):
//   - in_ready=0 during reset, 1 on the first cycle after it.
//   - out_valid=0, out_data=0, out_row=0, out_addr=0, out_sof=0, frame_done=0.
//   - Both bank-full flags cleared; write bank = read bank = 0; all pointers 0.
//   - Any partial strip is discarded; RAM contents need not be cleared.
//  Handshakes:
//   - A transfer occurs on an edge where valid&ready are both high.
//   - out_data, out_row, out_addr and out_sof stay stable while out_valid&!out_ready.
//  Write side:
//   - Pointers wr_row (0..7) and wr_col (0..WPR-1) into bank wr_bank.
//   - RAM address = wr_bank*8*WPR + wr_row*WPR + wr_col.
//   - in_ready = !full[wr_bank]; registered, so no same-cycle dependence on out_ready.
//   - Accepting the word at wr_row=7, wr_col=WPR-1 sets full[wr_bank], toggles wr_bank
//     and zeroes both pointers.
//  Read side FSM:
//   - IDLE: if full[rd_bank], issue a RAM read (sync read, 1-cycle latency) -> HOLD.
//   - HOLD: out_valid=1. On accept: if more words remain in the strip, issue the next
//     read in the same cycle and stay in HOLD (1 word/cycle throughput). Otherwise
//     clear full[rd_bank], toggle rd_bank -> IDLE.
//   - Read order: rd_blk 0..WPR-1 (outer), rd_row 0..7 (inner).
//     RAM address = rd_bank*8*WPR + rd_row*WPR + rd_blk; out_row = rd_row.
//  Latency:
//   - The last word of a strip accepted on edge E gives out_valid=1 after edge E+2,
//     provided the read side is IDLE.
//  Simultaneous events:
//   - A bank freed on edge E is writable from cycle E+1; never written on the edge
//     it is freed.
//   - Write and read to different banks in one cycle are always legal.
//   - When both banks are full, in_ready=0 until a drain completes.
//  Frame accounting:
//   - out_addr increments per accepted word and wraps to 0 after IMG_W*IMG_H/8-1
//     (natural 15-bit wrap at 512x512).
//   - out_sof is high while out_addr==0 and out_valid=1.
//   - frame_done pulses on the cycle after acceptance of word IMG_W*IMG_H/8-1.
//   - The next frame streams with no gap and no reset required.
// STRUCTURE
//  - jpeg_pkg holds: PIX_W=8, BLK_N=8, WORD_W=64, ADDR_W=15, read-FSM state encoding
//    (IDLE, HOLD).
//  - One sub-module, strip_ram: simple dual-port RAM, 1 write + 1 sync-read port,
//    depth 16*WPR, width 64, no read-during-write hazard since banks are disjoint.
//  - Top contains pointers, full flags, read FSM and output register.
// TESTING  (IMG_W=16, IMG_H=16, pixel value = {row[3:0],col[3:0]})
//  1. Reset, stream 32 words with out_ready=1.
//     -> Word 0 = 00_01_02..07 and out_sof=1; word 1 = 10_11..17 with out_row=1.
//     -> Word 8 = 08_09..0F (block 1, row 0); frame_done pulses after word 31.
//  2. Hold out_ready=0.
//     -> in_ready falls after exactly 32 accepted words.
//     -> out_valid=1 with out_data stable; no data lost when out_ready is released.
//  3. Last strip-0 word accepted on edge E with read side idle.
//     -> out_valid rises after edge E+2, out_addr=0.
//  4. Toggle in_valid and out_ready from random 50% masks for 3 frames.
//     -> Output matches the block-order model; out_addr wraps 31->0; out_sof once
//        per frame.
//  5. Assert reset after 20 input words and 5 outputs.
//     -> Next cycle: out_valid=0, out_addr=0. Restarted frame is output correctly
//        from word 0.
//  6. Free-flowing stream with in_valid=out_ready=1.
//     -> Once the pipeline is filled, in_ready stays 1 and output is 1 word/cycle.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared constants, read-FSM encoding and the strip-buffer address helper
// for the raster-to-block front end of the DCT pipeline.
package jpeg_pkg;

  localparam int PIX_W  = 8;
  localparam int BLK_N  = 8;
  localparam int WORD_W = PIX_W * BLK_N;
  localparam int ADDR_W = 15;

  // Read-side FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Word address inside the ping-pong buffer: each bank holds one 8-row strip,
  // laid out row-major with wpr words per row.
  function automatic int unsigned strip_addr(input logic        bank,
                                             input logic [2:0]  row,
                                             input int unsigned col,
                                             input int unsigned wpr);
    return (32'(bank) * 32'(BLK_N) + 32'(row)) * wpr + col;
  endfunction

endpackage

// File: rtl/raster_to_block_if.sv
// Stream interface of raster_to_block: raster input stream and block-order
// output stream with frame markers.
interface raster_to_block_if;
  import jpeg_pkg::*;

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_row;
  logic [ADDR_W-1:0] out_addr;
  logic              out_sof;
  logic              frame_done;

  // Environment side: produces raster words, consumes block rows
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_row, out_addr, out_sof, frame_done
  );

  // Design side
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_row, out_addr, out_sof, frame_done
  );
endinterface

// File: rtl/strip_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Write and read always target different banks, so no collision logic.
module strip_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage write port
  // NOTE: the storage array has no reset; only the read register is cleared,
  // since RAM contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  // Synchronous read register; holds its value when no read is issued
  always_ff @(posedge clk) begin
    if (reset)        rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/raster_to_block.sv
// Raster-to-block converter: buffers 8-row strips in a ping-pong RAM and
// re-emits each strip as 8x8 blocks, one block row per output beat.
module raster_to_block
  import jpeg_pkg::*;
#(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512
) (
  input logic              clk,
  input logic              reset,
  raster_to_block_if.slave bus
);

  localparam int unsigned WPR         = IMG_W / 8;
  localparam int          DEPTH       = 16 * IMG_W / 8;
  localparam int          RAM_AW      = $clog2(DEPTH);
  localparam int          COL_W       = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int          FRAME_WORDS = IMG_W * IMG_H / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WPR - 1);
  localparam logic [2:0]        LAST_ROW  = 3'(BLK_N - 1);

  // Write side
  logic [2:0]        wr_row_q, wr_row_d;
  logic [COL_W-1:0]  wr_col_q, wr_col_d;
  logic              wr_bank_q, wr_bank_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_fire, wr_last;
  logic              wr_en_q, wr_fill_q, wr_fill_bank_q;
  logic [RAM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q;

  // Bank status
  logic [1:0]        full_q, full_d;

  // Read side
  logic [0:0]        state_q, state_d;
  logic              rd_bank_q, rd_bank_d;
  logic [2:0]        rd_row_q, rd_row_d;
  logic [COL_W-1:0]  rd_blk_q, rd_blk_d;
  logic              rd_en, rd_last, rd_clear, out_fire;
  logic [RAM_AW-1:0] rd_addr;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              frame_done_q, frame_done_d;
  logic [WORD_W-1:0] ram_rd_data;

  // Raster write pointers and the registered in_ready
  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    wr_fire   = bus.in_valid && in_ready_q;
    wr_last   = (wr_row_q == LAST_ROW) && (wr_col_q == LAST_COL);
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    wr_bank_d = wr_bank_q;
    wr_addr_d = RAM_AW'(strip_addr(wr_bank_q, wr_row_q, 32'(wr_col_q), WPR));
    if (wr_fire) begin
      if (wr_last) begin
        wr_row_d  = '0;
        wr_col_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else if (wr_col_q == LAST_COL) begin
        wr_col_d = '0;
        wr_row_d = wr_row_q + 3'd1;
      end else begin
        wr_col_d = wr_col_q + COL_W'(1);
      end
    end
    // The bank just filled is never the new write bank, so its pending full
    // flag does not matter here; a bank freed this edge is writable next cycle.
    in_ready_d = !full_d[wr_bank_d];
  end

  // Read FSM: walks blocks (outer) and block rows (inner) of the full bank
  always_comb begin
    out_fire     = (state_q == ST_HOLD) && bus.out_ready;
    rd_last      = (rd_row_q == LAST_ROW) && (rd_blk_q == LAST_COL);
    state_d      = state_q;
    rd_bank_d    = rd_bank_q;
    rd_row_d     = rd_row_q;
    rd_blk_d     = rd_blk_q;
    rd_en        = 1'b0;
    rd_clear     = 1'b0;
    out_addr_d   = out_addr_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (full_q[rd_bank_q]) begin
          rd_en   = 1'b1;
          state_d = ST_HOLD;
        end
      end
      default: begin
        if (out_fire) begin
          out_addr_d   = (out_addr_q == LAST_ADDR) ? '0 : out_addr_q + ADDR_W'(1);
          frame_done_d = (out_addr_q == LAST_ADDR);
          if (!rd_last) begin
            rd_en = 1'b1;
            if (rd_row_q == LAST_ROW) begin
              rd_row_d = '0;
              rd_blk_d = rd_blk_q + COL_W'(1);
            end else begin
              rd_row_d = rd_row_q + 3'd1;
            end
          end else begin
            rd_clear  = 1'b1;
            rd_bank_d = ~rd_bank_q;
            rd_row_d  = '0;
            rd_blk_d  = '0;
            state_d   = ST_IDLE;
          end
        end
      end
    endcase
    rd_addr = RAM_AW'(strip_addr(rd_bank_d, rd_row_d, 32'(rd_blk_d), WPR));
  end

  // Bank-full flags: set once the strip's last word has landed in RAM,
  // cleared when the reader accepts the strip's last word
  always_comb begin
    full_d = full_q;
    if (wr_fill_q) full_d[wr_fill_bank_q] = 1'b1;
    if (rd_clear)  full_d[rd_bank_q]      = 1'b0;
  end

  // Control registers
  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_row_q       <= '0;
      wr_col_q       <= '0;
      wr_bank_q      <= 1'b0;
      in_ready_q     <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_fill_q      <= 1'b0;
      wr_fill_bank_q <= 1'b0;
      full_q         <= '0;
      state_q        <= ST_IDLE;
      rd_bank_q      <= 1'b0;
      rd_row_q       <= '0;
      rd_blk_q       <= '0;
      out_addr_q     <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      wr_row_q       <= wr_row_d;
      wr_col_q       <= wr_col_d;
      wr_bank_q      <= wr_bank_d;
      in_ready_q     <= in_ready_d;
      wr_en_q        <= wr_fire;
      wr_fill_q      <= wr_fire && wr_last;
      wr_fill_bank_q <= wr_bank_q;
      full_q         <= full_d;
      state_q        <= state_d;
      rd_bank_q      <= rd_bank_d;
      rd_row_q       <= rd_row_d;
      rd_blk_q       <= rd_blk_d;
      out_addr_q     <= out_addr_d;
      frame_done_q   <= frame_done_d;
    end
  end

  // Registered write port; qualified by wr_en_q so it needs no reset
  always_ff @(posedge clk) begin
    wr_addr_q <= wr_addr_d;
    wr_data_q <= bus.in_data;
  end

  strip_ram #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH),
    .AW    (RAM_AW)
  ) u_strip_ram (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_en_q),
    .wr_addr_i (wr_addr_q),
    .wr_data_i (wr_data_q),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (ram_rd_data)
  );

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = (state_q == ST_HOLD);
  assign bus.out_data   = ram_rd_data;
  assign bus.out_row    = rd_row_q;
  assign bus.out_addr   = out_addr_q;
  assign bus.out_sof    = (state_q == ST_HOLD) && (out_addr_q == '0);
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_raster_to_block.sv
// Scoreboard bench for raster_to_block on a 16x16 frame, pixel = {row,col}.
module tb_raster_to_block;
  import jpeg_pkg::*;

  localparam int IMG_W = 16;
  localparam int IMG_H = 16;
  localparam int WPR   = IMG_W / 8;
  localparam int FRAME = IMG_W * IMG_H / 8;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  row;
    logic [14:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  raster_to_block_if bus ();

  raster_to_block #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   out_mode = 0;   // 0 ready, 1 random, 2 stalled, 3 budgeted
  int   acc_limit = 0;
  int   acc_count = 0;
  int   sof_count = 0;
  bit   phase6 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pix_word(input int r, input int c);
    logic [63:0] w;
    logic [3:0]  rr;
    logic [3:0]  cc;
    rr = r[3:0];
    for (int k = 0; k < 8; k++) begin
      cc = 4'(8 * c + k);
      w[63 - 8*k -: 8] = {rr, cc};
    end
    return w;
  endfunction

  // Block order: strip (outer), block, row within block (inner)
  task automatic push_frame();
    exp_t e;
    for (int k = 0; k < FRAME; k++) begin
      e.row  = 3'(k % 8);
      e.data = pix_word(8 * (k / (8 * WPR)) + k % 8, (k % (8 * WPR)) / 8);
      e.addr = 15'(k);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive raster words first..first+n-1; returns cycles spent
  task automatic drive_words(input int first, input int n, input bit rnd, output int cycles);
    int k;
    bit acc;
    k = first;
    cycles = 0;
    while (k < first + n) begin
      bus.in_data  = pix_word(k / WPR, k % WPR);
      bus.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = bus.in_valid && bus.in_ready;
      tick();
      cycles++;
      if (acc) k++;
      if (cycles > 4000) begin
        errors++;
        $display("FAIL input_timeout: accepted %0d of %0d words", k - first, n);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 4000) begin
      tick();
      guard++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words still expected", exp_q.size());
    end
    repeat (3) tick();
  endtask

  // out_ready generator
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (out_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        2:       bus.out_ready = 1'b0;
        default: bus.out_ready = (acc_count < acc_limit);
      endcase
    end
  end

  // Monitor: compares every accepted output word with the scoreboard
  bit          fd_expect = 1'b0;
  bit          stall_prev = 1'b0;
  logic [63:0] stall_data;
  int          last_acc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      fd_expect  = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (fd_expect || bus.frame_done) check("frame_done", 64'(bus.frame_done), 64'(fd_expect));
      fd_expect = 1'b0;
      if (stall_prev) begin
        check("stall_valid", 64'(bus.out_valid), 64'(1));
        check("stall_data", bus.out_data, stall_data);
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h expected no output", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", bus.out_data, e.data);
          check("out_row", 64'(bus.out_row), 64'(e.row));
          check("out_addr", 64'(bus.out_addr), 64'(e.addr));
          check("out_sof", 64'(bus.out_sof), 64'(e.addr == 0));
          if (phase6 && (e.addr % 16) != 0) check("throughput", 64'(cyc), 64'(last_acc + 1));
          if (e.addr == 15'(FRAME - 1)) fd_expect = 1'b1;
        end
        last_acc = cyc;
        acc_count++;
        if (bus.out_sof) sof_count++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int sof0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // 1. Reset state, then one frame streamed with out_ready=1
    reset = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data", bus.out_data, 64'h0);
    check("rst_out_addr", 64'(bus.out_addr), 64'(0));
    check("rst_frame_done", 64'(bus.frame_done), 64'(0));
    reset = 1'b0;
    tick();
    check("in_ready_after_rst", 64'(bus.in_ready), 64'(1));
    check("vec_word0", pix_word(0, 0), 64'h0001020304050607);
    check("vec_word1", pix_word(1, 0), 64'h1011121314151617);
    check("vec_word8", pix_word(0, 1), 64'h08090A0B0C0D0E0F);
    out_mode = 0;
    push_frame();
    check("model_word0", exp_q[0].data, 64'h0001020304050607);
    check("model_word1_row", 64'(exp_q[1].row), 64'(1));
    check("model_word8", exp_q[8].data, 64'h08090A0B0C0D0E0F);
    check("model_word31", exp_q[31].data, 64'hF8F9FAFBFCFDFEFF);
    drive_words(0, FRAME, 1'b0, cycles);
    wait_drain();

    // 2. Downstream stalled: exactly 32 words accepted back to back
    out_mode = 2;
    push_frame();
    drive_words(0, FRAME, 1'b0, cycles);
    check("fill_cycles", 64'(cycles), 64'(FRAME));
    check("in_ready_full", 64'(bus.in_ready), 64'(0));
    repeat (4) tick();
    check("in_ready_still_full", 64'(bus.in_ready), 64'(0));
    check("stalled_valid", 64'(bus.out_valid), 64'(1));
    out_mode = 0;
    wait_drain();

    // 3. Latency from last strip-0 word to out_valid
    push_frame();
    drive_words(0, 8 * WPR, 1'b0, cycles);
    tick();
    check("lat_e1_valid", 64'(bus.out_valid), 64'(0));
    tick();
    check("lat_e2_valid", 64'(bus.out_valid), 64'(1));
    check("lat_e2_addr", 64'(bus.out_addr), 64'(0));
    drive_words(8 * WPR, FRAME - 8 * WPR, 1'b0, cycles);
    wait_drain();

    // 4. Random handshakes on both sides for 3 frames
    out_mode = 1;
    sof0 = sof_count;
    for (int f = 0; f < 3; f++) begin
      push_frame();
      drive_words(0, FRAME, 1'b1, cycles);
    end
    wait_drain();
    check("sof_per_frame", 64'(sof_count - sof0), 64'(3));

    // 5. Reset after 20 input words and 5 outputs
    acc_limit = acc_count;
    out_mode  = 3;
    push_frame();
    drive_words(0, 20, 1'b0, cycles);
    acc_limit = acc_count + 5;
    cycles = 0;
    while (acc_count < acc_limit && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check("five_outputs", 64'(acc_count), 64'(acc_limit));
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_out_addr", 64'(bus.out_addr), 64'(0));
    check("mid_rst_out_row", 64'(bus.out_row), 64'(0));
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
    reset = 1'b0;
    out_mode = 0;
    tick();
    check("mid_rst_in_ready_back", 64'(bus.in_ready), 64'(1));
    push_frame();
    drive_words(0, FRAME, 1'b0, cycles);
    wait_drain();

    // 6. Free-flowing stream: one word per cycle within each strip
    phase6 = 1'b1;
    push_frame();
    push_frame();
    drive_words(0, FRAME, 1'b0, cycles);
    drive_words(0, FRAME, 1'b0, cycles);
    wait_drain();
    phase6 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
